// File: rtl/seq_adder_pkg.sv
// Shared types and default sizing for the chunk-serial adder.
package seq_adder_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultChunk = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry in and carry out.
module chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum   = total[CHUNK-1:0];
    assign cout  = total[CHUNK];

endmodule

// File: rtl/seq_adder.sv
// Chunk-serial add/subtract unit: one CHUNK-bit slice per cycle, valid/ready on both sides.
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CHUNK = DefaultChunk
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_e                        state_q;
    logic [NCHUNK-1:0][CHUNK-1:0]  a_q;
    logic [NCHUNK-1:0][CHUNK-1:0]  b_q;
    logic [NCHUNK-1:0][CHUNK-1:0]  sum_q;
    logic                          carry_q;
    logic [IDX_W-1:0]              idx_q;
    logic                          cout_q;
    logic                          ovf_q;
    logic                          in_ready_q;
    logic                          out_valid_q;
    logic                          busy_q;

    logic [CHUNK-1:0]              chunk_sum;
    logic                          chunk_cout;

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk_adder (
        .a   (a_q[idx_q]),
        .b   (b_q[idx_q]),
        .cin (carry_q),
        .sum (chunk_sum),
        .cout(chunk_cout)
    );

    // b_q holds the effective operand (inverted for subtract) so RUN never looks at mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= sub ? ~b : b;
                        carry_q    <= sub ? 1'b1 : cin;
                        idx_q      <= '0;
                        state_q    <= StRun;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StRun: begin
                    sum_q[idx_q] <= chunk_sum;
                    carry_q      <= chunk_cout;
                    idx_q        <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= chunk_cout;
                        ovf_q       <= (a_q[NCHUNK-1][CHUNK-1] == b_q[NCHUNK-1][CHUNK-1]) &&
                                       (chunk_sum[CHUNK-1] != a_q[NCHUNK-1][CHUNK-1]);
                        idx_q       <= '0;
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: fixed vectors, random ops vs. a full-width model, corner sequences.
module tb_seq_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] prev_sum;
    logic             prev_cout;
    logic             prev_ovf;

    seq_adder #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Whole-word arithmetic: {ovf, cout, sum}.
    function automatic logic [WIDTH+1:0] ref_model(input logic [WIDTH-1:0] av,
                                                   input logic [WIDTH-1:0] bv,
                                                   input logic cv, input logic sv);
        logic [WIDTH-1:0] eb;
        logic [WIDTH:0]   t;
        logic             o;
        eb = sv ? ~bv : bv;
        t  = {1'b0, av} + {1'b0, eb} + (WIDTH+1)'(sv ? 1'b1 : cv);
        o  = (av[WIDTH-1] == eb[WIDTH-1]) && (t[WIDTH-1] != av[WIDTH-1]);
        return {o, t};
    endfunction

    // Launches one operation and checks every cycle up to the result; leaves the result unconsumed.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input logic sv, input logic [WIDTH-1:0] es,
                         input logic ec, input logic eo, input string tag);
        int   waitc;
        logic [31:0] mask;
        logic [WIDTH-1:0] part;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        for (int k = 1; k <= int'(NCHUNK); k++) begin
            @(posedge clk);
            #1;
            mask = (32'd1 << (k * CHUNK)) - 32'd1;
            part = WIDTH'((32'(es) & mask) | (32'(prev_sum) & ~mask));
            check($sformatf("%s sum after edge %0d", tag, k), 32'(sum), 32'(part));
            if (k < int'(NCHUNK)) begin
                check($sformatf("%s out_valid early edge %0d", tag, k), 32'(out_valid), 32'd0);
                check($sformatf("%s cout held edge %0d", tag, k), 32'(cout), 32'(prev_cout));
            end
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " busy done"}, 32'(busy), 32'd0);
        check({tag, " cout"}, 32'(cout), 32'(ec));
        check({tag, " ovf"}, 32'(ovf), 32'(eo));
        prev_sum  = es;
        prev_cout = ec;
        prev_ovf  = eo;
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready restored"}, 32'(in_ready), 32'd1);
        check({tag, " sum retained"}, 32'(sum), 32'(prev_sum));
    endtask

    vec_t vecs[6];
    logic [WIDTH+1:0] r;

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after reset", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp_sum,
                  vecs[i].exp_cout, vecs[i].exp_ovf, $sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic rc;
            logic rs;
            ra = WIDTH'($urandom); rb = WIDTH'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            r = ref_model(ra, rb, rc, rs);
            do_op(ra, rb, rc, rs, r[WIDTH-1:0], r[WIDTH], r[WIDTH+1], $sformatf("rnd%0d", i));
            release_result($sformatf("rnd%0d", i));
        end

        // Result held in DONE while a new request waits; it is taken only after the handshake.
        r = ref_model(16'h1111, 16'h2222, 1'b0, 1'b0);
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0, r[WIDTH-1:0], r[WIDTH], r[WIDTH+1], "hold");
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold out_valid %0d", k), 32'(out_valid), 32'd1);
            check($sformatf("hold in_ready %0d", k), 32'(in_ready), 32'd0);
            check($sformatf("hold busy %0d", k), 32'(busy), 32'd0);
            check($sformatf("hold sum %0d", k), 32'(sum), 32'h3333);
            check($sformatf("hold cout %0d", k), 32'(cout), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold released no accept", 32'(busy), 32'd0);
        check("hold released in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("hold late accept busy", 32'(busy), 32'd1);
        repeat (NCHUNK) @(posedge clk);
        #1;
        check("hold late out_valid", 32'(out_valid), 32'd1);
        check("hold late sum", 32'(sum), 32'h1010);
        prev_sum = 16'h1010; prev_cout = 1'b0; prev_ovf = 1'b0;
        release_result("hold late");

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        a = 16'h1111; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort partial sum", 32'(sum), 32'h1022);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort no result", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        r = ref_model(16'hABCD, 16'h1234, 1'b1, 1'b1);
        do_op(16'hABCD, 16'h1234, 1'b1, 1'b1, r[WIDTH-1:0], r[WIDTH], r[WIDTH+1], "post-reset");
        release_result("post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
